// File: rtl/dll_delay_ctrl_pkg.sv
// dll_pkg: shared types and helpers for the DDC delay-line controller
//   state_t    - controller state (IDLE/SAR/TRACK)
//   dir_t      - last tracking move (NONE/UP/DN)
//   sel_onehot - binary stage select to one-hot T code (truncate to N_STAGES at use)
package dll_pkg;
   localparam int MAX_STAGES = 1024;
   localparam int MAX_SEL_W  = 10;
   typedef enum logic [1:0] {IDLE = 2'd0, SAR = 2'd1, TRACK = 2'd2} state_t;
   typedef enum logic [1:0] {NONE = 2'd0, UP = 2'd1, DN = 2'd2} dir_t;
   function automatic logic [MAX_STAGES-1:0] sel_onehot(input logic [MAX_SEL_W-1:0] s);
      return MAX_STAGES'(1) << s;
   endfunction
endpackage

// File: rtl/dll_delay_ctrl_settle_timer.sv
// dll_settle_timer: loadable down-counter gating phase-detector samples after a sel change
//   clk, rst - clock, synchronous active-high reset
//   load     - reload the counter to LOAD_VAL
//   ready    - count has reached zero
module dll_settle_timer #(
   parameter int LOAD_VAL = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   output logic ready
);
   logic [3:0] count;
   always_ff @(posedge clk)
      if (rst) count <= '0;
      else if (load) count <= 4'(LOAD_VAL);
      else if (count != '0) count <= count - 4'd1;
   assign ready = count == '0;
endmodule

// File: rtl/dll_delay_ctrl.sv
// dll_delay_ctrl: SAR-then-track turnaround-stage controller for the FMDLL DDC chain
//   clk, rst          - clock, synchronous active-high reset
//   en                - run acquisition/tracking
//   pd_valid/up/dn    - phase detector strobe and request
//   freeze            - hold tracking (only with DLL_DELAY_CTRL_FREEZE_EN defined)
//   sel               - binary turnaround stage
//   t_code/tb_code    - one-hot stage code and its complement
//   busy/locked/sat   - activity, lock, end-of-chain saturation
module dll_delay_ctrl
   import dll_pkg::*;
#(
   parameter int N_STAGES   = 32,
   parameter int SEL_W      = $clog2(N_STAGES),
   parameter int SETTLE_CYC = 4,
   parameter int LOCK_CNT   = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                pd_valid,
   input  logic                pd_up,
   input  logic                pd_dn,
`ifdef DLL_DELAY_CTRL_FREEZE_EN
   input  logic                freeze,
`endif
   output logic [SEL_W-1:0]    sel,
   output logic [N_STAGES-1:0] t_code,
   output logic [N_STAGES-1:0] tb_code,
   output logic                busy,
   output logic                locked,
   output logic                sat
);
   state_t state, state_n;
   dir_t last_dir, dir_n;
   logic [SEL_W-1:0] idx, idx_n, sel_n, mask, trial;
   logic [7:0] lock_cnt, lock_n;
   logic [N_STAGES-1:0] onehot_n;
   logic busy_n, sat_n, load, ready, acc, up_only, dn_only, blk, mv_up, mv_dn, frz;
`ifdef DLL_DELAY_CTRL_FREEZE_EN
   assign frz = freeze;
`else
   assign frz = 1'b0;
`endif
   assign acc     = pd_valid & ready;
   assign up_only = pd_up & ~pd_dn;
   assign dn_only = pd_dn & ~pd_up;
   // SAR trial: drop the bit under test on dn-only, then raise the next lower bit
   assign mask    = SEL_W'(1) << idx;
   assign trial   = (dn_only ? sel & ~mask : sel) | (mask >> 1);
   assign blk     = (up_only && sel == '1) || (dn_only && sel == '0);
   assign mv_up   = up_only & ~blk;
   assign mv_dn   = dn_only & ~blk;
   assign onehot_n = N_STAGES'(sel_onehot(MAX_SEL_W'(sel_n)));
   always_comb begin
      state_n = state;
      sel_n   = sel;
      idx_n   = idx;
      busy_n  = busy;
      sat_n   = sat;
      lock_n  = lock_cnt;
      dir_n   = last_dir;
      load    = 1'b0;
      if (!en) begin
         state_n = IDLE;
         busy_n  = 1'b0;
         sat_n   = 1'b0;
         lock_n  = '0;
         dir_n   = NONE;
      end else if (state == IDLE) begin
         state_n = SAR;
         sel_n   = SEL_W'(N_STAGES / 2);
         idx_n   = SEL_W'(SEL_W - 1);
         busy_n  = 1'b1;
         load    = 1'b1;
      end else if (state == SAR && acc) begin
         sel_n   = trial;
         idx_n   = idx == '0 ? idx : idx - SEL_W'(1);
         state_n = idx == '0 ? TRACK : SAR;
         load    = 1'b1;
      end else if (state == TRACK && acc && !frz) begin
         sel_n  = mv_up ? sel + SEL_W'(1) : mv_dn ? sel - SEL_W'(1) : sel;
         load   = mv_up | mv_dn;
         dir_n  = mv_up ? UP : mv_dn ? DN : last_dir;
         sat_n  = blk;
         // a repeat of the previous direction means the loop is still slewing, not dithering
         lock_n = (blk || (mv_up && last_dir == UP) || (mv_dn && last_dir == DN)) ? '0 :
                  (lock_cnt == 8'(LOCK_CNT)) ? lock_cnt : lock_cnt + 8'd1;
      end
   end
   always_ff @(posedge clk)
      if (rst) begin
         state    <= IDLE;
         sel      <= '0;
         t_code   <= N_STAGES'(1);
         tb_code  <= ~N_STAGES'(1);
         idx      <= '0;
         lock_cnt <= '0;
         last_dir <= NONE;
         busy     <= 1'b0;
         locked   <= 1'b0;
         sat      <= 1'b0;
      end else begin
         state    <= state_n;
         sel      <= sel_n;
         t_code   <= onehot_n;
         tb_code  <= ~onehot_n;
         idx      <= idx_n;
         lock_cnt <= lock_n;
         last_dir <= dir_n;
         busy     <= busy_n;
         locked   <= lock_n == 8'(LOCK_CNT);
         sat      <= sat_n;
      end
   dll_settle_timer #(.LOAD_VAL(SETTLE_CYC)) u_settle (
      .clk   (clk),
      .rst   (rst),
      .load  (load),
      .ready (ready)
   );
endmodule

// File: tb/tb_dll_delay_ctrl.sv
// tb_dll_delay_ctrl: scoreboard bench for dll_delay_ctrl
module tb_dll_delay_ctrl;
   logic clk = 1'b0;
   logic rst, en, pd_valid, pd_up, pd_dn;
   logic [4:0] sel;
   logic [31:0] t_code, tb_code;
   logic busy, locked, sat;
`ifdef DLL_DELAY_CTRL_FREEZE_EN
   logic freeze;
`endif
   int vectors = 0;
   int miscompares = 0;
   int cur;
   int sar21[5] = '{24, 20, 22, 21, 21};
   int sar31[5] = '{24, 28, 30, 31, 31};
   typedef struct {
      string tag;
      int    sel;
      logic  busy;
      logic  locked;
      logic  sat;
   } exp_t;
   exp_t sb[$];
   always #5 clk = ~clk;
   dll_delay_ctrl dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .pd_valid (pd_valid),
      .pd_up    (pd_up),
      .pd_dn    (pd_dn),
`ifdef DLL_DELAY_CTRL_FREEZE_EN
      .freeze   (freeze),
`endif
      .sel      (sel),
      .t_code   (t_code),
      .tb_code  (tb_code),
      .busy     (busy),
      .locked   (locked),
      .sat      (sat)
   );
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic pop_check();
      exp_t e;
      logic [31:0] oh;
      e  = sb.pop_front();
      oh = 32'd1 << e.sel;
      check({e.tag, ".sel"}, 32'(sel), 32'(e.sel));
      check({e.tag, ".t_code"}, t_code, oh);
      check({e.tag, ".tb_code"}, tb_code, ~oh);
      check({e.tag, ".busy"}, 32'(busy), 32'(e.busy));
      check({e.tag, ".locked"}, 32'(locked), 32'(e.locked));
      check({e.tag, ".sat"}, 32'(sat), 32'(e.sat));
   endtask
   task automatic step(input string tag, input int es, input logic eb, input logic el, input logic esat);
      exp_t e;
      e.tag = tag; e.sel = es; e.busy = eb; e.locked = el; e.sat = esat;
      sb.push_back(e);
      @(negedge clk);
      pop_check();
   endtask
   // four settle-window cycles (optionally carrying dn-only noise strobes), then one real sample
   task automatic sample(input string tag, input logic up, input logic dn, input logic noise,
                         input int es, input logic el, input logic esat);
      for (int i = 0; i < 4; i++) begin
         pd_valid = noise; pd_up = 1'b0; pd_dn = noise;
         @(negedge clk);
      end
      pd_valid = 1'b1; pd_up = up; pd_dn = dn;
      step(tag, es, 1'b1, el, esat);
      pd_valid = 1'b0;
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end
   initial begin
      rst = 1'b1; en = 1'b0; pd_valid = 1'b0; pd_up = 1'b0; pd_dn = 1'b0;
`ifdef DLL_DELAY_CTRL_FREEZE_EN
      freeze = 1'b0;
`endif
      repeat (2) @(negedge clk);
      rst = 1'b0;
      step("reset", 0, 1'b0, 1'b0, 1'b0);
      en = 1'b1;
      step("start", 16, 1'b1, 1'b0, 1'b0);
      cur = 16;
      for (int i = 0; i < 5; i++) begin
         sample($sformatf("sar21_%0d", i), cur < 21, cur > 21, 1'b1, sar21[i], 1'b0, 1'b0);
         cur = sar21[i];
      end
      for (int i = 0; i < 8; i++)
         sample($sformatf("lock_%0d", i), i % 2 == 0, i % 2 == 1, 1'b0, (i % 2 == 0) ? 22 : 21, i == 7, 1'b0);
      rst = 1'b1;
      step("rst_mid", 0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      step("restart", 16, 1'b1, 1'b0, 1'b0);
      cur = 16;
      for (int i = 0; i < 5; i++) begin
         sample($sformatf("sar21b_%0d", i), cur < 21, cur > 21, 1'b0, sar21[i], 1'b0, 1'b0);
         cur = sar21[i];
      end
      sample("hold_both", 1'b1, 1'b1, 1'b0, 21, 1'b0, 1'b0);
      for (int i = 0; i < 7; i++)
         sample($sformatf("relock_%0d", i), i % 2 == 0, i % 2 == 1, 1'b0, (i % 2 == 0) ? 22 : 21, i == 6, 1'b0);
      sample("same_dir", 1'b1, 1'b0, 1'b0, 23, 1'b0, 1'b0);
      en = 1'b0;
      step("en_off", 23, 1'b0, 1'b0, 1'b0);
      en = 1'b1;
      step("en_on", 16, 1'b1, 1'b0, 1'b0);
      cur = 16;
      for (int i = 0; i < 2; i++) begin
         sample($sformatf("sar_ab_%0d", i), cur < 21, cur > 21, 1'b0, sar21[i], 1'b0, 1'b0);
         cur = sar21[i];
      end
      en = 1'b0;
      step("abort", 20, 1'b0, 1'b0, 1'b0);
      en = 1'b1;
      step("re_en", 16, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++)
         sample($sformatf("sar31_%0d", i), 1'b1, 1'b0, 1'b0, sar31[i], 1'b0, 1'b0);
      sample("blocked", 1'b1, 1'b0, 1'b0, 31, 1'b0, 1'b1);
      sample("unblock", 1'b0, 1'b1, 1'b0, 30, 1'b0, 1'b0);
`ifdef DLL_DELAY_CTRL_FREEZE_EN
      freeze = 1'b1;
      sample("frz_0", 1'b1, 1'b0, 1'b0, 30, 1'b0, 1'b0);
      sample("frz_1", 1'b1, 1'b0, 1'b0, 30, 1'b0, 1'b0);
      freeze = 1'b0;
      sample("unfrz", 1'b1, 1'b0, 1'b0, 31, 1'b0, 1'b0);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/dll_delay_ctrl.md
Name: dll_delay_ctrl

Overview:
- Digital delay-line controller for the FMDLL's DDC chain: sets the turnaround stage of an N_STAGES delay line from phase-detector feedback.
- Runs a binary (SAR) coarse search, then switches to ±1 tracking and raises `locked` once the loop dithers stably.
- Drives the T/Tb pair of every DDC stage; sits between the phase detector and the delay line.

Parameters:
- N_STAGES, 32, number of DDC stages; must be a power of 2, ≥4.
- SEL_W, $clog2(N_STAGES), width of the stage select.
- SETTLE_CYC, 4, clocks to wait after every `sel` change before a PD sample is accepted (1..15).
- LOCK_CNT, 8, consecutive non-monotonic tracking samples required to assert `locked` (1..255).

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  level; 1 = run acquisition/tracking.
- pd_valid  in  1  one-cycle strobe; pd_up/pd_dn valid.
- pd_up  in  1  delay too short, increase.
- pd_dn  in  1  delay too long, decrease.
- sel  out  SEL_W  current turnaround stage (binary).
- t_code  out  N_STAGES  one-hot, t_code[sel]=1; drives DDC T inputs.
- tb_code  out  N_STAGES  always ~t_code; drives DDC Tb inputs.
- busy  out  1  high in SAR/SETTLE/TRACK.
- locked  out  1  tracking lock indication.
- sat  out  1  registered; high while a tracking request was blocked at a chain end.

Behaviour:
- Reset (rst=1 at posedge, any state):
  - State IDLE, sel=0, t_code=1, tb_code=~1.
  - locked=0, busy=0, sat=0.
  - Settle counter, bit index and lock counter all 0.
- All outputs registered; t_code/tb_code update in the same cycle as sel.
- States: IDLE, SAR, TRACK. Each holds an internal settle counter; pd_valid is ignored while the counter is nonzero.
- Settle rule: every sel write reloads the counter to SETTLE_CYC.
- IDLE:
  - en=1 → SAR; sel=N_STAGES/2 (MSB trial), bit index=SEL_W-1, busy=1.
- SAR, on an accepted pd_valid:
  - If pd_dn=1 and pd_up=0: clear the current bit. Otherwise keep it; both-high or both-low counts as keep.
  - If bit index>0: set the next lower bit, decrement the index, reload settle.
  - If bit index==0: → TRACK and reload settle.
  - Exactly SEL_W trials are taken.
- TRACK, on an accepted pd_valid:
  - up-only and sel<N_STAGES-1 → sel+1.
  - dn-only and sel>0 → sel-1.
  - Both or neither → hold.
  - Blocked at an end (up at max, dn at 0) → hold, sat=1. sat clears on the next accepted sample that is not blocked.
- Lock counter (TRACK only):
  - Increment, saturating at LOCK_CNT, on a hold, or on a move opposite to the previous move.
  - Clear on a move in the same direction as the previous move, or on a blocked request.
  - locked = (counter==LOCK_CNT), registered, so it rises the cycle after the LOCK_CNT-th qualifying sample.
  - The first move after entering TRACK has no previous direction and counts as a reversal.
- en=0 in any state → IDLE next cycle.
  - busy=0, locked=0, sat=0, lock counter cleared.
  - sel, t_code and tb_code retain their values.
  - Re-enable always restarts SAR at N_STAGES/2.
- pd_valid in IDLE: ignored.

Optional Feature:
- Macro DLL_DELAY_CTRL_FREEZE_EN.
- Defined: adds input port `freeze` (1 bit).
  - In TRACK with freeze=1, accepted samples are discarded: sel, lock counter, locked and sat all hold.
  - No effect in SAR or IDLE.
- Undefined: no port; behaviour as if freeze=0.

Decomposition:
- Package dll_pkg holds:
  - the state enum (IDLE/SAR/TRACK);
  - the direction enum (NONE/UP/DN) for last-move tracking;
  - a function converting sel to one-hot t_code.
- One sub-module, dll_settle_timer: loadable down-counter with a `ready` output (count==0) and a load input. It is instantiated once and reloaded on every sel write.

Test Plan:
- Reset: rst high 2 cycles, then low with en=0 → sel=0, t_code=32'h0000_0001, tb_code=32'hFFFF_FFFE, busy=0, locked=0.
- SAR to target 21: PD model gives up if sel<21, dn if sel>21, neither if equal. Trials are 16 keep, 24 clear, 20 keep, 22 clear, 21 keep → sel=21, state TRACK after exactly 5 accepted samples. pd_valid pulses inside the 4-cycle settle windows cause no change.
- Lock: in TRACK at sel=21, alternate up/dn samples → sel toggles 22/21. locked=1 the cycle after the 8th sample. Then two consecutive up moves → locked=0.
- Saturation: PD always up → SAR ends sel=31. A TRACK up sample holds at 31, sat=1, locked stays 0. A following dn sample → sel=30, sat=0.
- Abort: drop en during the 3rd SAR trial (sel=20) → next cycle busy=0, sel=20 held. Re-raise en → sel=16 and SAR restarts.
- Reset mid-lock: rst=1 for 1 cycle while locked=1, sel=21 → next cycle sel=0, t_code=1, locked=0, busy=0, state IDLE even with en=1. SAR restarts the cycle after rst drops.
- (With DLL_DELAY_CTRL_FREEZE_EN) freeze=1 in TRACK with up samples → sel and locked unchanged.
